// File: rtl/regfile_2r1w_clr_if.sv
// Operand/write-back bus of the decode-stage register file.
//
// master : the pipeline side. Drives both read addresses, the write-back
//          triple (we, wr_addr, wr_data) and the clr_req pulse. Receives the
//          read data, busy and wr_drop.
// slave  : the register file. The directions of the master side are reversed.
interface regfile_2r1w_clr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;

  modport master (
    output rs_addr, rt_addr, we, wr_addr, wr_data, clr_req,
    input  rs_data, rt_data, busy, wr_drop
  );

  modport slave (
    input  rs_addr, rt_addr, we, wr_addr, wr_data, clr_req,
    output rs_data, rt_data, busy, wr_drop
  );
endinterface

// File: rtl/regfile_2r1w_clr.sv
// Decode-stage register file.
// - Two combinational read ports (Rs/Rt) with write-to-read bypass.
// - One clocked write port.
// - An optional hardwired zero register.
// - A sequenced bulk clear that sweeps one register per cycle.
//
// Ports:
//   clk   : rising-edge clock.
//   rst_n : asynchronous, active-low reset. It re-initialises every register
//           and aborts any clear in progress.
//   bus   : regfile_2r1w_clr_if.slave. It carries:
//           - rs_addr/rt_addr -> rs_data/rt_data (combinational reads);
//           - we/wr_addr/wr_data (write-back);
//           - clr_req (starts a clear);
//           - busy (clear in progress, registered);
//           - wr_drop (registered; high for one cycle after a write was
//             discarded by a clear).
module regfile_2r1w_clr #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_2r1w_clr_if.slave   bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {IDLE, CLEAR} stateT;

  stateT             stateReg, stateNext;
  logic [ADDR_W-1:0] clrCntReg, clrCntNext;
  logic              wrDropReg, wrDropNext;
  logic [DATA_W-1:0] regArray [DEPTH];

  logic busy;
  logic wrToZero;
  logic wrEn;
  logic rsHit;
  logic rtHit;

  // Value held by register idx after reset or after a clear.
  function automatic logic [DATA_W-1:0] initVal(input logic [ADDR_W-1:0] idx);
    if (INIT_MODE != 0) initVal = DATA_W'(idx);
    else                initVal = '0;
  endfunction

  assign busy     = (stateReg == CLEAR);
  assign wrToZero = (ZERO_REG != 0) && (bus.wr_addr == '0);
  // A clear owns the array. Writes arriving during a clear are discarded and
  // never bypassed.
  assign wrEn     = bus.we & ~busy & ~wrToZero;

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      clrCntReg <= '0;
      wrDropReg <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      clrCntReg <= clrCntNext;
      wrDropReg <= wrDropNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    clrCntNext = clrCntReg;
    wrDropNext = bus.we & busy;
    case (stateReg)
      IDLE: begin
        if (bus.clr_req) begin
          stateNext  = CLEAR;
          clrCntNext = '0;
        end
      end
      CLEAR: begin
        // Compare against all-ones, so the sweep covers each index exactly once.
        clrCntNext = clrCntReg + ADDR_W'(1);
        if (clrCntReg == LAST_IDX) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Storage. The asynchronous reset has to re-initialise every entry at once,
  // so the array is built from flops rather than from RAM.
  // With ZERO_REG, entry 0 starts at 0 in both init modes. It never takes a
  // write, and a clear also loads it with 0, so it stays 0 without any
  // special read path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regArray[i] <= initVal(ADDR_W'(i));
    end else begin
      if (wrEn) regArray[bus.wr_addr] <= bus.wr_data;
      if (busy) regArray[clrCntReg]   <= initVal(clrCntReg);
    end
  end

  // Read ports with same-cycle bypass of the write-back data
  assign rsHit = wrEn && (bus.wr_addr == bus.rs_addr);
  assign rtHit = wrEn && (bus.wr_addr == bus.rt_addr);

  assign bus.rs_data = rsHit ? bus.wr_data : regArray[bus.rs_addr];
  assign bus.rt_data = rtHit ? bus.wr_data : regArray[bus.rt_addr];
  assign bus.busy    = busy;
  assign bus.wr_drop = wrDropReg;

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Two instances get the same stimulus:
// - dutA: ZERO_REG=1, INIT_MODE=1.
// - dutB: ZERO_REG=0, INIT_MODE=0.
// The driver computes each cycle's expected outputs from a behavioural model
// and queues them. A monitor pops one entry per cycle and compares on the
// falling edge.
module tb_regfile_2r1w_clr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_2r1w_clr_if #(.DATA_W(32), .ADDR_W(5)) busA ();
  regfile_2r1w_clr_if #(.DATA_W(32), .ADDR_W(5)) busB ();

  regfile_2r1w_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .INIT_MODE(1)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA)
  );
  regfile_2r1w_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .INIT_MODE(0)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB)
  );

  typedef struct {
    int              cyc;
    logic [1:0][31:0] rs;
    logic [1:0][31:0] rt;
    logic [1:0]       busy;
    logic [1:0]       drop;
  } expT;

  expT expQ[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cycNo       = 0;

  // Reference model. Index 0 models dutA, index 1 models dutB.
  logic [31:0] mem [2][32];
  int          clearLeft [2];   // busy cycles still to run
  logic        dropQ [2];       // wr_drop value visible this cycle

  function automatic logic [31:0] initOf(int d, int i);
    return (d == 0) ? 32'(i) : 32'd0;
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) mem[d][i] = initOf(d, i);
      clearLeft[d] = 0;
      dropQ[d]     = 1'b0;
    end
  endfunction

  function automatic logic [31:0] expRead(int d, logic [4:0] a, logic we,
                                          logic [4:0] wa, logic [31:0] wd);
    if (d == 0 && a == 5'd0) return 32'd0;
    if (we && clearLeft[d] == 0 && wa == a) return wd;
    return mem[d][a];
  endfunction

  function automatic void modelEdge(int d, logic we, logic [4:0] wa,
                                    logic [31:0] wd, logic clr);
    if (clearLeft[d] > 0) begin
      mem[d][32 - clearLeft[d]] = initOf(d, 32 - clearLeft[d]);
      clearLeft[d]--;
      dropQ[d] = we;
    end else begin
      if (we && !(d == 0 && wa == 5'd0)) mem[d][wa] = wd;
      dropQ[d] = 1'b0;
      if (clr) clearLeft[d] = 32;
    end
  endfunction

  // Drive one cycle (at posedge+1), queue the expectation, then step to the next cycle
  task automatic applyCycle(input logic rstLow, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [4:0] ra,
                            input logic [4:0] rb, input logic clr);
    expT e;
    rst_n        = ~rstLow;
    busA.we      = we;  busB.we      = we;
    busA.wr_addr = wa;  busB.wr_addr = wa;
    busA.wr_data = wd;  busB.wr_data = wd;
    busA.rs_addr = ra;  busB.rs_addr = ra;
    busA.rt_addr = rb;  busB.rt_addr = rb;
    busA.clr_req = clr; busB.clr_req = clr;
    if (rstLow) modelReset();
    e.cyc = cycNo;
    for (int d = 0; d < 2; d++) begin
      e.busy[d] = (clearLeft[d] > 0);
      e.drop[d] = dropQ[d];
      e.rs[d]   = expRead(d, ra, we, wa, wd);
      e.rt[d]   = expRead(d, rb, we, wa, wd);
      if (!rstLow) modelEdge(d, we, wa, wd, clr);
    end
    expQ.push_back(e);
    cycNo++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    applyCycle(1'b0, 1'b0, 5'd0, 32'd0, ra, rb, 1'b0);
  endtask

  // Monitor / scoreboard
  task automatic check(input string name, input int d, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  initial begin
    expT e;
    logic [31:0] aRs [2];
    logic [31:0] aRt [2];
    logic        aBusy [2];
    logic        aDrop [2];
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        aRs[0] = busA.rs_data;  aRs[1] = busB.rs_data;
        aRt[0] = busA.rt_data;  aRt[1] = busB.rt_data;
        aBusy[0] = busA.busy;   aBusy[1] = busB.busy;
        aDrop[0] = busA.wr_drop; aDrop[1] = busB.wr_drop;
        for (int d = 0; d < 2; d++) begin
          check("rs_data", d, e.cyc, aRs[d], e.rs[d]);
          check("rt_data", d, e.cyc, aRt[d], e.rt[d]);
          check("busy",    d, e.cyc, 32'(aBusy[d]), 32'(e.busy[d]));
          check("wr_drop", d, e.cyc, 32'(aDrop[d]), 32'(e.drop[d]));
        end
        $display("cycle %0d: A rs=%h rt=%h busy=%b drop=%b | B rs=%h rt=%h busy=%b drop=%b",
                 e.cyc, aRs[0], aRt[0], aBusy[0], aDrop[0], aRs[1], aRt[1], aBusy[1], aDrop[1]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [4:0]  wa, ra, rb;
    logic [31:0] wd;
    logic        we, clr, rl;
    rst_n = 1'b0;
    busA.we = 1'b0; busB.we = 1'b0;
    busA.clr_req = 1'b0; busB.clr_req = 1'b0;
    busA.wr_addr = '0; busB.wr_addr = '0;
    busA.wr_data = '0; busB.wr_data = '0;
    busA.rs_addr = '0; busB.rs_addr = '0;
    busA.rt_addr = '0; busB.rt_addr = '0;
    @(posedge clk);
    #1;
    applyCycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    applyCycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0);

    // Read back the post-reset contents at every address on both ports
    for (int a = 0; a < 32; a++) idle(5'(a), 5'(31 - a));

    // Same-cycle bypass, then the value through the array
    applyCycle(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0, 1'b0);
    idle(5'd7, 5'd7);

    // Write to register 0
    applyCycle(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd7);

    // Clear with a write dropped partway through
    applyCycle(1'b0, 1'b1, 5'd3,  32'hA5A5A5A5, 5'd3, 5'd31, 1'b0);
    applyCycle(1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd3, 5'd31, 1'b0);
    applyCycle(1'b0, 1'b0, 5'd0,  32'd0,        5'd3, 5'd31, 1'b1);
    for (int i = 0; i < 33; i++) begin
      if (i == 5) applyCycle(1'b0, 1'b1, 5'd10, 32'hCAFEF00D, 5'd10, 5'd3, 1'b0);
      else        idle(5'd3, 5'd31);
    end
    idle(5'd10, 5'd3);
    idle(5'd31, 5'd10);

    // clr_req together with a write: the write lands, then the sweep clears it
    applyCycle(1'b0, 1'b1, 5'd4, 32'h55, 5'd4, 5'd4, 1'b1);
    for (int i = 0; i < 34; i++) idle(5'd4, 5'd0);

    // Reset asserted partway through a clear
    applyCycle(1'b0, 1'b1, 5'd20, 32'hFF, 5'd20, 5'd20, 1'b0);
    applyCycle(1'b0, 1'b0, 5'd0,  32'd0,  5'd20, 5'd20, 1'b1);
    for (int i = 0; i < 10; i++) idle(5'd20, 5'd2);
    applyCycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd20, 5'd2, 1'b0);
    applyCycle(1'b0, 1'b1, 5'd2, 32'h77, 5'd2, 5'd20, 1'b0);
    idle(5'd2, 5'd20);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom);
      wd  = $urandom;
      ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      clr = ($urandom_range(0, 60) == 0);
      rl  = ($urandom_range(0, 250) == 0);
      applyCycle(rl, we, wa, wd, ra, rb, clr);
    end
    idle(5'd0, 5'd1);

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
